// File: rtl/mem_bist_if.sv
// Memory-side bus between the BIST initiator and the dual-port memory.
// Write and read ports are independent; rd_data follows rd_en by one cycle.
interface mem_bist_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRSIZE   = 4
);
  logic                  wr_en;
  logic [ADDRSIZE-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDRSIZE-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/mem_bist.sv
// March-style memory BIST: write pattern, read/check, write inverse, read/check.
// Reads are checked one cycle later to match the memory's registered read port.
module mem_bist #(
  parameter int          DATA_WIDTH = 8,
  parameter int          MAX_ADDR   = 16,
  parameter int          ADDRSIZE   = $clog2(MAX_ADDR),
  parameter int unsigned SEED       = 'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshake: start is a level sampled only in IDLE (no ready); done is a
  // single-cycle pulse, and pass/err_count/first_err_addr hold until the next start.
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDRSIZE+1:0]   err_count,
  output logic [ADDRSIZE-1:0]   first_err_addr,
  output logic [2:0]            dbg_state,
  mem_bist_if.master            mem
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_RD0  = 3'd2,
    S_WR1  = 3'd3,
    S_RD1  = 3'd4,
    S_FIN  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  localparam logic [ADDRSIZE-1:0]   LAST_ADDR = ADDRSIZE'(MAX_ADDR - 1);
  localparam logic [DATA_WIDTH-1:0] SEED_W    = DATA_WIDTH'(SEED);
  localparam logic [ADDRSIZE+1:0]   ERR_MAX   = '1;

  state_e                state_q, state_d;
  logic [ADDRSIZE-1:0]   addr_q, addr_d;
  logic                  chk_valid_q, chk_valid_d;
  logic [ADDRSIZE-1:0]   chk_addr_q, chk_addr_d;
  logic [DATA_WIDTH-1:0] chk_exp_q, chk_exp_d;
  logic [ADDRSIZE+1:0]   err_count_q, err_count_d;
  logic [ADDRSIZE-1:0]   first_err_q, first_err_d;
  logic                  pass_q, pass_d;

  logic                  wr_en_c, rd_en_c, access_c, last_c, mismatch_c;
  logic [ADDRSIZE-1:0]   wr_addr_c, rd_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c, expected_c, pat_c;

  assign pat_c  = DATA_WIDTH'(addr_q) ^ SEED_W;
  assign last_c = (addr_q == LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_en_c    = 1'b0;
    rd_en_c    = 1'b0;
    wr_addr_c  = '0;
    rd_addr_c  = '0;
    wr_data_c  = '0;
    expected_c = '0;
    access_c   = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_WR0;
      S_WR0: begin
        access_c  = 1'b1;
        wr_en_c   = 1'b1;
        wr_addr_c = addr_q;
        wr_data_c = pat_c;
        if (last_c) state_d = S_RD0;
      end
      S_RD0: begin
        access_c   = 1'b1;
        rd_en_c    = 1'b1;
        rd_addr_c  = addr_q;
        expected_c = pat_c;
        if (last_c) state_d = S_WR1;
      end
      S_WR1: begin
        access_c  = 1'b1;
        wr_en_c   = 1'b1;
        wr_addr_c = addr_q;
        wr_data_c = ~pat_c;
        if (last_c) state_d = S_RD1;
      end
      S_RD1: begin
        access_c   = 1'b1;
        rd_en_c    = 1'b1;
        rd_addr_c  = addr_q;
        expected_c = ~pat_c;
        if (last_c) state_d = S_FIN;
      end
      S_FIN:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The counter wraps at LAST_ADDR so non-power-of-two sizes never overrun.
    if (access_c) addr_d = last_c ? '0 : addr_q + 1'b1;
    else          addr_d = '0;
  end

  // Each read registers its address and expected word; the compare happens
  // in the following cycle when the memory presents rd_data.
  always_comb begin
    chk_valid_d = rd_en_c;
    chk_addr_d  = addr_q;
    chk_exp_d   = expected_c;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    mismatch_c  = chk_valid_q && (mem.rd_data != chk_exp_q);
    if (mismatch_c) begin
      if (err_count_q != ERR_MAX) err_count_d = err_count_q + 1'b1;
      if (err_count_q == '0)      first_err_d = chk_addr_q;
    end
    if (state_q == S_FIN) pass_d = (err_count_d == '0);
    if (state_q == S_IDLE && start) begin
      err_count_d = '0;
      first_err_d = '0;
      pass_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      chk_valid_q <= 1'b0;
      chk_addr_q  <= '0;
      chk_exp_q   <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      chk_valid_q <= chk_valid_d;
      chk_addr_q  <= chk_addr_d;
      chk_exp_q   <= chk_exp_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign mem.wr_en   = wr_en_c;
  assign mem.wr_addr = wr_addr_c;
  assign mem.wr_data = wr_data_c;
  assign mem.rd_en   = rd_en_c;
  assign mem.rd_addr = rd_addr_c;

  assign busy           = access_c || (state_q == S_FIN);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: two instances (16 and 12 words) against behavioural
// memories with selectable stuck-at-0 faults, driven from a vector table.
module tb_mem_bist;
  localparam int DW = 8;
  localparam int N0 = 16;
  localparam int N1 = 12;
  localparam int AS = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start0, start1, sel;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [AS+1:0] errc0, errc1;
  logic [AS-1:0] fea0, fea1;
  logic [2:0]    st0, st1;
  int fault_mode;
  int n_vec = 0;
  int n_miss = 0;

  mem_bist_if #(.DATA_WIDTH(DW), .ADDRSIZE(AS)) mif0 ();
  mem_bist_if #(.DATA_WIDTH(DW), .ADDRSIZE(AS)) mif1 ();

  mem_bist #(.DATA_WIDTH(DW), .MAX_ADDR(N0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(errc0), .first_err_addr(fea0),
    .dbg_state(st0), .mem(mif0.master)
  );

  mem_bist #(.DATA_WIDTH(DW), .MAX_ADDR(N1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(errc1), .first_err_addr(fea1),
    .dbg_state(st1), .mem(mif1.master)
  );

  // Memory models: registered read, stuck-at-0 bits applied on write.
  logic [DW-1:0] mem0 [16];
  logic [DW-1:0] mem1 [16];

  function automatic logic [DW-1:0] fmask(input int a);
    if (fault_mode == 1 && a == 5)              return 8'hFE;
    if (fault_mode == 2 && (a == 3 || a == 9))  return 8'h7F;
    return 8'hFF;
  endfunction

  always @(posedge clk) begin
    if (mif0.wr_en) mem0[mif0.wr_addr] <= mif0.wr_data & fmask(int'(mif0.wr_addr));
    if (mif0.rd_en) mif0.rd_data <= mem0[mif0.rd_addr];
    if (mif1.wr_en) mem1[mif1.wr_addr] <= mif1.wr_data & fmask(int'(mif1.wr_addr));
    if (mif1.rd_en) mif1.rd_data <= mem1[mif1.rd_addr];
  end

  logic          c_busy, c_done, c_pass, c_wr_en, c_rd_en;
  logic [AS+1:0] c_err;
  logic [AS-1:0] c_fea, c_wr_addr, c_rd_addr;
  logic [DW-1:0] c_wr_data;
  assign c_busy    = sel ? busy1 : busy0;
  assign c_done    = sel ? done1 : done0;
  assign c_pass    = sel ? pass1 : pass0;
  assign c_err     = sel ? errc1 : errc0;
  assign c_fea     = sel ? fea1  : fea0;
  assign c_wr_en   = sel ? mif1.wr_en   : mif0.wr_en;
  assign c_rd_en   = sel ? mif1.rd_en   : mif0.rd_en;
  assign c_wr_addr = sel ? mif1.wr_addr : mif0.wr_addr;
  assign c_rd_addr = sel ? mif1.rd_addr : mif0.rd_addr;
  assign c_wr_data = sel ? mif1.wr_data : mif0.wr_data;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  typedef struct {
    int sel;
    int fault;
    int poke_a;
    int poke_b;
    int post;
    int exp_pass;
    int exp_err;
    int exp_first;
    int exp_err_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int busy_cnt, busy_last, done_cnt, done_cyc, err_cyc;
    logic [W-1:0] exp_wr_q [$];
    logic [W-1:0] exp_rd_q [$];
    n = (v.sel != 0) ? N1 : N0;
    busy_cnt = 0; busy_last = 0; done_cnt = 0; done_cyc = 0; err_cyc = 0;
    sel = (v.sel != 0);
    fault_mode = v.fault;
    for (int a = 0; a < n; a++) exp_wr_q.push_back({8'(a), pat(a)});
    for (int a = 0; a < n; a++) exp_rd_q.push_back({8'(a), 8'h00});
    for (int a = 0; a < n; a++) exp_wr_q.push_back({8'(a), ~pat(a)});
    for (int a = 0; a < n; a++) exp_rd_q.push_back({8'(a), 8'h00});
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    for (int c = 1; c <= 4 * n + 2 + v.post; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("err_cleared_at_start", int'(c_err), 0);
        check("pass_cleared_at_start", int'(c_pass), 0);
      end
      if (c_busy) begin busy_cnt++; busy_last = c; end
      if (c_done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
      if (err_cyc == 0 && c_err != 0) err_cyc = c;
      if (c_wr_en) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", 1, 0);
        else check("write_addr_data", int'({8'(c_wr_addr), c_wr_data}), int'(exp_wr_q.pop_front()));
      end
      if (c_rd_en) begin
        if (exp_rd_q.size() == 0) check("unexpected_read", 1, 0);
        else check("read_addr", int'({8'(c_rd_addr), 8'h00}), int'(exp_rd_q.pop_front()));
      end
      if (c == 4 * n + 2) begin
        check("pass", int'(c_pass), v.exp_pass);
        check("err_count", int'(c_err), v.exp_err);
        check("first_err_addr", int'(c_fea), v.exp_first);
      end
      set_start(c == v.poke_a || c == v.poke_b);
    end
    check("busy_cycles", busy_cnt, 4 * n + 1);
    check("busy_last_cycle", busy_last, 4 * n + 1);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_cyc, 4 * n + 2);
    check("err_visible_cycle", err_cyc, v.exp_err_cyc);
    check("writes_left", exp_wr_q.size(), 0);
    check("reads_left", exp_rd_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy0), 0);
    check({tag, "_done"}, int'(done0), 0);
    check({tag, "_pass"}, int'(pass0), 0);
    check({tag, "_err"}, int'(errc0), 0);
    check({tag, "_first"}, int'(fea0), 0);
    check({tag, "_wr_en"}, int'(mif0.wr_en), 0);
    check({tag, "_rd_en"}, int'(mif0.rd_en), 0);
    check({tag, "_wr_addr"}, int'(mif0.wr_addr), 0);
    check({tag, "_rd_addr"}, int'(mif0.rd_addr), 0);
    check({tag, "_wr_data"}, int'(mif0.wr_data), 0);
    check({tag, "_state"}, int'(st0), 0);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    //          sel flt pk_a pk_b post pass err first err_cyc
    vecs[0] = '{0,  0,  0,   0,   3,   1,   0,  0,    0};
    vecs[1] = '{0,  1,  0,   0,   3,   0,   1,  5,    56};
    vecs[2] = '{0,  2,  0,   0,   3,   0,   2,  3,    22};
    vecs[3] = '{1,  0,  0,   0,   3,   1,   0,  0,    0};
    vecs[4] = '{0,  1,  40,  66,  0,   0,   1,  5,    56};
    vecs[5] = '{0,  0,  0,   0,   3,   1,   0,  0,    0};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0; fault_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_busy_n12", int'(busy1), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset during RD0: next cycle idle with reset outputs, no done pulse.
    sel = 1'b0; fault_mode = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    rst = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
    end
    check("after_reset_busy", busy_cnt, 0);
    check("after_reset_done", done_cnt, 0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
